// File: rtl/htif_pcr_arbiter.sv
// Two-requester arbiter in front of the core HTIF PCR port: round-robin grant,
// one transaction outstanding, timeout completion with late-response discard.
module htif_pcr_arbiter #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_rw,
    input  logic [2*AW-1:0]   req_addr,
    input  logic [2*DW-1:0]   req_data,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DW-1:0]     resp_data,
    output logic              resp_err,
    output logic              pcr_req_valid,
    input  logic              pcr_req_ready,
    output logic              pcr_req_rw,
    output logic [AW-1:0]     pcr_req_addr,
    output logic [DW-1:0]     pcr_req_data,
    input  logic              pcr_resp_valid,
    output logic              pcr_resp_ready,
    input  logic [DW-1:0]     pcr_resp_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            gnt_q, gnt_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            drop_q, drop_d;

    logic            gnt_sel;
    logic [1:0]      req_ready_int;

    always_comb begin
        // Round-robin only matters under contention; an idle bus parks on the pointer.
        if (req_valid == 2'b11) gnt_sel = ptr_q;
        else if (req_valid[1])  gnt_sel = 1'b1;
        else if (req_valid[0])  gnt_sel = 1'b0;
        else                    gnt_sel = ptr_q;
        req_ready_int = (state_q == S_IDLE) ? {gnt_sel, ~gnt_sel} : 2'b00;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = '0;
        drop_d  = drop_q;

        // A timed-out response may still arrive; swallow it outside WAIT.
        if (drop_q && state_q != S_WAIT && pcr_resp_valid) drop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid[gnt_sel]) begin
                    gnt_d   = gnt_sel;
                    ptr_d   = ~gnt_sel;
                    rw_d    = req_rw[gnt_sel];
                    addr_d  = gnt_sel ? req_addr[AW +: AW] : req_addr[0 +: AW];
                    wdata_d = gnt_sel ? req_data[DW +: DW] : req_data[0 +: DW];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!drop_q && pcr_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pcr_resp_valid) begin
                    rdata_d = pcr_resp_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    drop_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (resp_ready[gnt_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs are gated by reset so they read zero while reset is held, not just after the edge.
    assign req_ready      = reset ? req_ready_int : 2'b00;
    assign resp_valid     = (reset && state_q == S_RESP) ? {gnt_q, ~gnt_q} : 2'b00;
    assign resp_data      = reset ? rdata_q : '0;
    assign resp_err       = reset & err_q;
    assign pcr_req_valid  = reset && state_q == S_REQ && !drop_q;
    assign pcr_req_rw     = reset & rw_q;
    assign pcr_req_addr   = reset ? addr_q : '0;
    assign pcr_req_data   = reset ? wdata_q : '0;
    assign pcr_resp_ready = reset && (state_q == S_WAIT || drop_q);

endmodule

// File: tb/tb_htif_pcr_arbiter.sv
// Scoreboard bench for htif_pcr_arbiter: requester drivers, a scripted core model
// and a response monitor that pops expected completions.
module tb_htif_pcr_arbiter;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req_valid, req_ready, req_rw;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_data;
    logic [1:0]        resp_valid, resp_ready;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic              pcr_req_valid, pcr_req_ready, pcr_req_rw;
    logic [AW-1:0]     pcr_req_addr;
    logic [DW-1:0]     pcr_req_data;
    logic              pcr_resp_valid, pcr_resp_ready;
    logic [DW-1:0]     pcr_resp_data;

    always #5 clk = ~clk;

    htif_pcr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready),
        .pcr_req_rw(pcr_req_rw), .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready),
        .pcr_resp_data(pcr_resp_data)
    );

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } rq_t;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            stall;   // cycles pcr_req_ready held low
        int            delay;   // WAIT cycles before the response; -1 never
        logic [DW-1:0] data;
    } core_t;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        logic          err;
        int            lat;     // accept-to-resp_valid cycles; 0 unchecked
    } exp_t;

    rq_t   rq0[$];
    rq_t   rq1[$];
    core_t cq[$];
    exp_t  eq[$];

    int cyc = 0;
    int last_acc = 0;
    int rstall[2] = '{0, 0};
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester drivers: present the queue head, drop it one negedge after acceptance.
    initial begin
        bit acc[2];
        rq_t r;
        acc = '{0, 0};
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
        forever begin
            @(negedge clk);
            if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
            if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
            for (int i = 0; i < 2; i++) begin
                acc[i] = 0;
                if (reset && ((i == 0) ? rq0.size() : rq1.size()) > 0) begin
                    r = (i == 0) ? rq0[0] : rq1[0];
                    req_valid[i] = 1'b1;
                    req_rw[i] = r.rw;
                    req_addr[i*AW +: AW] = r.addr;
                    req_data[i*DW +: DW] = r.wdata;
                end else begin
                    req_valid[i] = 1'b0;
                    req_rw[i] = 1'b0;
                    req_addr[i*AW +: AW] = '0;
                    req_data[i*DW +: DW] = '0;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc[i] = 1;
                    last_acc = cyc;
                end
            end
        end
    end

    // Core model: checks request fields, stalls, then answers after a scripted delay.
    initial begin
        bit    busy;
        int    wcnt;
        core_t cur;
        busy = 0; wcnt = 0;
        pcr_req_ready = 1'b0; pcr_resp_valid = 1'b0; pcr_resp_data = '0;
        forever begin
            @(negedge clk);
            pcr_req_ready = 1'b0; pcr_resp_valid = 1'b0; pcr_resp_data = '0;
            if (!reset) begin
                busy = 0;
            end else if (!busy) begin
                if (pcr_req_valid) begin
                    if (cq.size() == 0) begin
                        check("core_unexpected_req", 160'(pcr_req_valid), 160'(0));
                    end else begin
                        check("pcr_req_fields", 160'({pcr_req_rw, pcr_req_addr, pcr_req_data}),
                              160'({cq[0].rw, cq[0].addr, cq[0].wdata}));
                        if (cq[0].stall > 0) begin
                            cq[0].stall = cq[0].stall - 1;
                        end else begin
                            cur = cq.pop_front();
                            pcr_req_ready = 1'b1;
                            busy = 1;
                            wcnt = 0;
                        end
                    end
                end
            end else begin
                check("pcr_req_valid_outstanding", 160'(pcr_req_valid), 160'(0));
                if (cur.delay >= 0 && wcnt >= cur.delay) begin
                    pcr_resp_valid = 1'b1;
                    pcr_resp_data = cur.data;
                    if (pcr_resp_ready) busy = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Response monitor: applies requester backpressure and scores each presented response.
    initial begin
        bit   first;
        exp_t e;
        first = 1;
        resp_ready = 2'b11;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                resp_ready[i] = 1'b1;
                if (resp_valid[i] && rstall[i] > 0) begin
                    resp_ready[i] = 1'b0;
                    rstall[i]--;
                end
            end
            if (!reset) begin
                first = 1;
            end else if (resp_valid != 2'b00) begin
                if (eq.size() == 0) begin
                    check("unexpected_resp", 160'(resp_valid), 160'(0));
                end else begin
                    e = eq[0];
                    check("resp_valid", 160'(resp_valid), 160'((e.who == 1) ? 2'b10 : 2'b01));
                    check("resp_data", 160'(resp_data), 160'(e.data));
                    check("resp_err", 160'(resp_err), 160'(e.err));
                    if (first && e.lat > 0) check("latency", 160'(cyc - last_acc), 160'(e.lat));
                    first = 0;
                    if (resp_ready[e.who]) begin
                        void'(eq.pop_front());
                        first = 1;
                    end
                end
            end
        end
    end

    task automatic txn(input int who, input logic rw, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int stall, input int delay,
                       input logic [DW-1:0] cdata, input bit has_resp,
                       input logic [DW-1:0] edata, input logic eerr, input int lat);
        rq_t r; core_t c; exp_t e;
        r.rw = rw; r.addr = addr; r.wdata = wd;
        if (who == 0) rq0.push_back(r); else rq1.push_back(r);
        c.rw = rw; c.addr = addr; c.wdata = wd; c.stall = stall; c.delay = delay; c.data = cdata;
        cq.push_back(c);
        if (has_resp) begin
            e.who = who; e.data = edata; e.err = eerr; e.lat = lat;
            eq.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((eq.size() + cq.size() + rq0.size() + rq1.size()) > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 160'(eq.size() + cq.size() + rq0.size() + rq1.size()), 160'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 160'({req_ready, resp_valid, resp_data, resp_err, pcr_req_valid,
                          pcr_resp_ready, pcr_req_addr, pcr_req_data, pcr_req_rw}), 160'(0));
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check_reset_outputs("reset_outputs");
        @(posedge clk); #3 reset = 1'b1;

        // Single read, core answers at once.
        txn(0, 1'b0, 12'h780, 64'h0, 0, 0, 64'h1, 1, 64'h1, 1'b0, 3);
        wait_done("single_read_done");

        // Write from requester 1, core answers after two WAIT cycles.
        txn(1, 1'b1, 12'h123, 64'h0000_0000_DEAD_BEEF, 0, 2, 64'h5A5A, 1, 64'h5A5A, 1'b0, 5);
        wait_done("write_done");

        // Contention: both requesters queued, expected grant order 0,1,0,1.
        txn(0, 1'b0, 12'h010, 64'h0, 0, 0, 64'h1111, 1, 64'h1111, 1'b0, 3);
        txn(1, 1'b1, 12'h020, 64'h55, 0, 0, 64'h2222, 1, 64'h2222, 1'b0, 3);
        txn(0, 1'b0, 12'h030, 64'h0, 0, 0, 64'h3333, 1, 64'h3333, 1'b0, 3);
        txn(1, 1'b1, 12'h040, 64'hAA, 0, 0, 64'h4444, 1, 64'h4444, 1'b0, 3);
        wait_done("contention_done");

        // Backpressure: core stalls 5 cycles, requester 1 holds resp_ready low 3 cycles.
        rstall[1] = 3;
        txn(1, 1'b1, 12'h7C0, 64'h0123_4567_89AB_CDEF, 5, 1, 64'hCAFE, 1, 64'hCAFE, 1'b0, 9);
        wait_done("backpressure_done");

        // Timeout after 4 WAIT cycles; the late 0xDEAD lands while the next request sits in REQ.
        txn(0, 1'b0, 12'h100, 64'h0, 0, 6, 64'hDEAD, 1, 64'h0, 1'b1, 6);
        txn(0, 1'b0, 12'h104, 64'h0, 0, 0, 64'hBEEF, 1, 64'hBEEF, 1'b0, 4);
        wait_done("timeout_done");

        // Reset while waiting on a core that never answers.
        txn(0, 1'b0, 12'h200, 64'h0, 0, -1, 64'h0, 0, 64'h0, 1'b0, 0);
        n = 0;
        while (!pcr_resp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait", 160'(pcr_resp_ready), 160'(1));
        @(posedge clk); #3 reset = 1'b0;
        @(negedge clk); #2;
        check_reset_outputs("reset_in_wait_outputs");
        @(posedge clk); #3 reset = 1'b1;

        // After reset the pointer favours requester 0.
        txn(0, 1'b0, 12'h300, 64'h0, 0, 0, 64'h3030, 1, 64'h3030, 1'b0, 3);
        txn(1, 1'b0, 12'h310, 64'h0, 0, 0, 64'h3131, 1, 64'h3131, 1'b0, 3);
        wait_done("post_reset_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
